// File: rtl/io_responder_pkg.sv
// Shared IO-space map for io_responder: register word addresses, CTRL bit
// positions and the timer register-select encoding.
package io_responder_pkg;

    localparam logic [7:0] IO_ADDR_ID       = 8'h00;
    localparam logic [7:0] IO_ADDR_GPIO_OUT = 8'h01;
    localparam logic [7:0] IO_ADDR_GPIO_IN  = 8'h02;
    localparam logic [7:0] IO_ADDR_CNT      = 8'h03;
    localparam logic [7:0] IO_ADDR_CMP      = 8'h04;
    localparam logic [7:0] IO_ADDR_CTRL     = 8'h05;
    localparam logic [7:0] IO_ADDR_PRESCALE = 8'h06;
    localparam logic [7:0] IO_SCRATCH_BASE  = 8'h80;

    localparam int CTRL_RUN      = 0;
    localparam int CTRL_AUTO_CLR = 1;
    localparam int CTRL_FLAG     = 2;
    localparam int CTRL_IRQ_EN   = 3;

    // Ordered so that io_addr - IO_ADDR_CNT gives the select directly.
    typedef enum logic [1:0] {
        TMR_CNT      = 2'd0,
        TMR_CMP      = 2'd1,
        TMR_CTRL     = 2'd2,
        TMR_PRESCALE = 2'd3
    } tmr_sel_e;

    typedef struct packed {
        logic irq_en;
        logic flag;
        logic auto_clr;
        logic run;
    } ctrl_t;

endpackage

// File: rtl/io_responder_timer.sv
// io_timer: prescaled 32-bit up-counter with compare match, sticky W1C flag
// and level interrupt. Register writes arrive as strobe + select + data.
module io_timer
    import io_responder_pkg::*;
(
    input  logic        clk,
    input  logic        resetb,
    input  logic        wr_en,
    input  tmr_sel_e    wr_sel,
    input  logic [31:0] wr_data,
    output logic [31:0] cnt,
    output logic [31:0] cmp,
    output ctrl_t       ctrl,
    output logic [15:0] prescale,
    output logic        irq
);

    logic [15:0] pre_cnt;
    logic [31:0] cnt_inc;
    logic        wr_cnt, wr_cmp, wr_ctrl, wr_pre;
    logic        tick, match;

    assign wr_cnt  = wr_en && (wr_sel == TMR_CNT);
    assign wr_cmp  = wr_en && (wr_sel == TMR_CMP);
    assign wr_ctrl = wr_en && (wr_sel == TMR_CTRL);
    assign wr_pre  = wr_en && (wr_sel == TMR_PRESCALE);

    assign cnt_inc = cnt + 32'd1;
    assign tick    = ctrl.run && (pre_cnt == prescale);
    // A CNT write swallows the tick, so it cannot raise a match either.
    assign match   = tick && !wr_cnt && (cnt_inc == cmp);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt      <= '0;
            cmp      <= 32'hFFFF_FFFF;
            ctrl     <= '0;
            prescale <= '0;
            pre_cnt  <= '0;
        end else begin
            if (wr_cnt) begin
                cnt     <= wr_data;
                pre_cnt <= '0;
            end else if (ctrl.run) begin
                pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
                if (tick)
                    cnt <= (match && ctrl.auto_clr) ? 32'd0 : cnt_inc;
            end
            if (wr_cmp)
                cmp <= wr_data;
            if (wr_pre)
                prescale <= wr_data[15:0];
            if (wr_ctrl) begin
                ctrl.run      <= wr_data[CTRL_RUN];
                ctrl.auto_clr <= wr_data[CTRL_AUTO_CLR];
                ctrl.irq_en   <= wr_data[CTRL_IRQ_EN];
            end
            // Set wins over a same-cycle write-one-to-clear.
            ctrl.flag <= match | (ctrl.flag & ~(wr_ctrl & wr_data[CTRL_FLAG]));
        end
    end

    assign irq = ctrl.flag & ctrl.irq_en;

endmodule

// File: rtl/io_responder.sv
// io_responder: IO-bus target with ID, GPIO, scratch RAM and optional timer.
// Define IO_TIMER_EN to build the timer at 0x03-0x06 and drive timer_irq.
module io_responder
    import io_responder_pkg::*;
#(
    parameter int          GPIO_W     = 8,
    parameter int          SCRATCH_AW = 7,
    parameter logic [31:0] ID_VALUE   = 32'h494F_0001
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              io_en,
    input  logic              io_we,
    input  logic [7:0]        io_addr,
    input  logic [31:0]       io_data_write,
    output logic [31:0]       io_data_read,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int SCRATCH_WORDS = 1 << SCRATCH_AW;
`ifdef IO_TIMER_EN
    localparam logic TIMER_PRESENT = 1'b1;
`else
    localparam logic TIMER_PRESENT = 1'b0;
`endif

    logic [31:0] id_word;
    logic        acc_wr, acc_rd, is_scratch;
    logic [1:0][GPIO_W-1:0] gpio_sync;
    logic [31:0] mem [SCRATCH_WORDS];
    logic [31:0] ram_q, reg_q, reg_rd;
    logic        ram_sel;

    assign id_word = {ID_VALUE[31:9], TIMER_PRESENT, ID_VALUE[7:0]};

    // Gating with resetb keeps the un-reset RAM from taking writes during reset.
    assign acc_wr     = io_en &  io_we & resetb;
    assign acc_rd     = io_en & ~io_we & resetb;
    assign is_scratch = io_addr[7] && ((io_addr[6:0] >> SCRATCH_AW) == 7'd0);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            gpio_sync <= '0;
            gpio_out  <= '0;
        end else begin
            gpio_sync <= {gpio_sync[0], gpio_in};
            if (acc_wr && io_addr == IO_ADDR_GPIO_OUT)
                gpio_out <= io_data_write[GPIO_W-1:0];
        end
    end

`ifdef IO_TIMER_EN
    logic [31:0] tmr_cnt, tmr_cmp;
    ctrl_t       tmr_ctrl;
    logic [15:0] tmr_prescale;
    logic        tmr_we;
    tmr_sel_e    tmr_sel;

    assign tmr_we  = acc_wr && io_addr >= IO_ADDR_CNT && io_addr <= IO_ADDR_PRESCALE;
    assign tmr_sel = tmr_sel_e'(2'(io_addr - IO_ADDR_CNT));

    io_timer u_timer (
        .clk      (clk),
        .resetb   (resetb),
        .wr_en    (tmr_we),
        .wr_sel   (tmr_sel),
        .wr_data  (io_data_write),
        .cnt      (tmr_cnt),
        .cmp      (tmr_cmp),
        .ctrl     (tmr_ctrl),
        .prescale (tmr_prescale),
        .irq      (timer_irq)
    );
`else
    assign timer_irq = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (acc_wr && is_scratch)
            mem[io_addr[SCRATCH_AW-1:0]] <= io_data_write;
        if (acc_rd && is_scratch)
            ram_q <= mem[io_addr[SCRATCH_AW-1:0]];
    end

    always_comb begin
        reg_rd = '0;
        case (io_addr)
            IO_ADDR_ID:       reg_rd = id_word;
            IO_ADDR_GPIO_OUT: reg_rd = 32'(gpio_out);
            IO_ADDR_GPIO_IN:  reg_rd = 32'(gpio_sync[1]);
`ifdef IO_TIMER_EN
            IO_ADDR_CNT:      reg_rd = tmr_cnt;
            IO_ADDR_CMP:      reg_rd = tmr_cmp;
            IO_ADDR_CTRL:     reg_rd = 32'(tmr_ctrl);
            IO_ADDR_PRESCALE: reg_rd = 32'(tmr_prescale);
`endif
            default:          reg_rd = '0;
        endcase
    end

    // Register reads and RAM reads land in separate flops; ram_sel picks the
    // one the latest read targeted so the result holds until the next read.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            reg_q   <= '0;
            ram_sel <= 1'b0;
        end else if (acc_rd) begin
            reg_q   <= reg_rd;
            ram_sel <= is_scratch;
        end
    end

    assign io_data_read = ram_sel ? ram_q : reg_q;

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder; timer checks are built when IO_TIMER_EN is defined.
module tb_io_responder;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        io_en = 1'b0;
    logic        io_we = 1'b0;
    logic [7:0]  io_addr = 8'h00;
    logic [31:0] io_data_write = 32'h0;
    logic [31:0] io_data_read;
    logic [7:0]  gpio_in = 8'h00;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] scratch_m [128];
`ifdef IO_TIMER_EN
    localparam logic [31:0] ID_EXP = 32'h494F_0101;
`else
    localparam logic [31:0] ID_EXP = 32'h494F_0001;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    io_responder dut (
        .clk           (clk),
        .resetb        (resetb),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_addr       (io_addr),
        .io_data_write (io_data_write),
        .io_data_read  (io_data_read),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .timer_irq     (timer_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        io_en = 1'b1; io_we = 1'b1; io_addr = a; io_data_write = d;
        @(posedge clk);
        #1 io_en = 1'b0; io_we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        io_en = 1'b1; io_we = 1'b0; io_addr = a;
        @(posedge clk);
        #1 d = io_data_read;
        io_en = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, last;
        logic [7:0]  a, g;
        int w;

        // reset state
        #1;
        check("rst_data_read", io_data_read, 32'h0);
        check("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
        check("rst_timer_irq", {31'h0, timer_irq}, 32'h0);
        gpio_in = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetb = 1'b1;

        rd(8'h00, d);
        check("id", d, ID_EXP);

        // scratch: random fill, then back-to-back readback
        for (int i = 0; i < 128; i++) begin
            scratch_m[i] = $urandom();
            wr(8'(128 + i), scratch_m[i]);
        end
        for (int i = 0; i < 128; i++) begin
            rd(8'(128 + i), d);
            check($sformatf("scratch[%0d]", i), d, scratch_m[i]);
        end
        last = scratch_m[127];
        repeat (3) @(posedge clk);
        #1 check("read_hold_idle", io_data_read, last);
        wr(8'h90, 32'hDEAD_BEEF);
        scratch_m[16] = 32'hDEAD_BEEF;
        check("read_hold_write", io_data_read, last);
        rd(8'h90, d);
        check("scratch_rewrite", d, scratch_m[16]);

        // unmapped addresses read 0 and ignore writes
        wr(8'h07, 32'h1234_5678);
        rd(8'h07, d);
        check("unmapped_07", d, 32'h0);
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom_range(7, 127));
            wr(a, $urandom());
            rd(a, d);
            check($sformatf("unmapped_%h", a), d, 32'h0);
        end

        // GPIO out
        wr(8'h01, 32'hFFFF_FF5A);
        check("gpio_out_5a", {24'h0, gpio_out}, 32'h5A);
        rd(8'h01, d);
        check("gpio_out_rd", d, 32'h5A);
        for (int i = 0; i < 4; i++) begin
            d = $urandom();
            g = d[7:0];
            wr(8'h01, d);
            check("gpio_out_rand", {24'h0, gpio_out}, {24'h0, g});
            rd(8'h01, d);
            check("gpio_out_rand_rd", d, {24'h0, g});
        end

        // GPIO in through the 2-flop synchronizer
        @(negedge clk);
        gpio_in = 8'h3C; io_en = 1'b1; io_we = 1'b0; io_addr = 8'h02;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1 check($sformatf("gpio_in_plus%0d", k), io_data_read, (k < 3) ? 32'hA5 : 32'h3C);
        end
        io_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g = 8'($urandom());
            gpio_in = g;
            repeat (3) @(posedge clk);
            rd(8'h02, d);
            check("gpio_in_rand", d, {24'h0, g});
        end

`ifdef IO_TIMER_EN
        // register readback
        d = $urandom();
        wr(8'h04, d);
        rd(8'h04, last);
        check("cmp_rd", last, d);
        wr(8'h06, 32'hABCD_1234);
        rd(8'h06, d);
        check("prescale_rd", d, 32'h0000_1234);

        // period 4 ticks, match after 4 ticks -> 16 cycles, auto_clr
        wr(8'h06, 32'd3);
        wr(8'h04, 32'd4);
        wr(8'h03, 32'd0);
        wr(8'h05, 32'b1011);
        w = cyc;
        wait_until(w + 15);
        check("irq_before_match", {31'h0, timer_irq}, 32'h0);
        wait_until(w + 16);
        check("irq_at_match", {31'h0, timer_irq}, 32'h1);
        rd(8'h03, d);
        check("cnt_auto_clr", d, 32'h0);
        rd(8'h05, d);
        check("ctrl_flag_set", d, 32'hF);
        wr(8'h05, 32'hF);
        check("irq_w1c", {31'h0, timer_irq}, 32'h0);
        wait_until(w + 31);
        wr(8'h05, 32'hF);
        check("irq_w1c_on_match", {31'h0, timer_irq}, 32'h1);
        rd(8'h03, d);
        check("cnt_second_match", d, 32'h0);

        // wrap and CNT-write collision with every-cycle ticks
        wr(8'h05, 32'h4);
        check("irq_stop_clear", {31'h0, timer_irq}, 32'h0);
        wr(8'h06, 32'd0);
        wr(8'h04, 32'h10);
        wr(8'h03, 32'hFFFF_FFFF);
        wr(8'h05, 32'h1);
        rd(8'h03, d);
        check("cnt_pre_wrap", d, 32'hFFFF_FFFF);
        rd(8'h03, d);
        check("cnt_wrap", d, 32'h0);
        wr(8'h03, 32'd7);
        rd(8'h03, d);
        check("cnt_write_beats_tick", d, 32'd7);
        rd(8'h03, d);
        check("cnt_after_write", d, 32'd8);
        wr(8'h05, 32'h0);
        repeat (5) @(posedge clk);
        rd(8'h03, d);
        check("cnt_frozen", d, 32'd10);

        // reset mid-run
        wr(8'h03, 32'd5);
        wr(8'h05, 32'h1);
        repeat (3) @(posedge clk);
`else
        for (int i = 3; i <= 6; i++) begin
            wr(8'(i), $urandom() | 32'h1);
            rd(8'(i), d);
            check($sformatf("no_timer_reg_%0d", i), d, 32'h0);
        end
        check("no_timer_irq", {31'h0, timer_irq}, 32'h0);
`endif
        rd(8'h00, d);
        check("id_before_reset", d, ID_EXP);
        @(posedge clk);
        #2;
        resetb = 1'b0;
        io_en = 1'b1; io_we = 1'b1; io_addr = 8'h01; io_data_write = 32'hFF;
        #1;
        check("midrst_data_read", io_data_read, 32'h0);
        check("midrst_gpio_out", {24'h0, gpio_out}, 32'h0);
        check("midrst_timer_irq", {31'h0, timer_irq}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        io_en = 1'b0; io_we = 1'b0;
        resetb = 1'b1;
        #1 check("postrst_gpio_out", {24'h0, gpio_out}, 32'h0);
        rd(8'h01, d);
        check("postrst_gpio_rd", d, 32'h0);
`ifdef IO_TIMER_EN
        rd(8'h03, d);
        check("postrst_cnt", d, 32'h0);
        rd(8'h04, d);
        check("postrst_cmp", d, 32'hFFFF_FFFF);
        rd(8'h05, d);
        check("postrst_ctrl", d, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
